// File: rtl/ascensor_pkg.sv
// rtl/ascensor_pkg.sv - shared encodings for the car controller and the dispatcher
//
// Purpose: direction codes, the "no destination" word and the car state
// encodings. The dispatcher imports the same package, so these values are
// the contract between the two blocks.
package ascensor_pkg;

  typedef enum logic [1:0] {
    REPOSO   = 2'b00,
    MOVIENDO = 2'b01,
    PUERTA   = 2'b10
  } estado_t;

  localparam logic [1:0] DIR_NADA   = 2'b00;
  localparam logic [1:0] DIR_ARRIBA = 2'b01;
  localparam logic [1:0] DIR_ABAJO  = 2'b10;

  localparam logic [2:0] DEST_NADA  = 3'b100;

endpackage

// File: rtl/temporizador_carga.sv
// rtl/temporizador_carga.sv - loadable down-counter with a zero flag
//
// Purpose: holds the remaining cycles of the current travel or door phase.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset (count cleared to 0)
//   load   load valor this edge (has priority over counting)
//   valor  value to load
//   cero   count is zero
// The count decrements every edge while non-zero and then parks at zero.
module temporizador_carga #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [ANCHO-1:0] valor,
  output logic             cero
);

  localparam logic [ANCHO-1:0] UNO = {{(ANCHO-1){1'b0}}, 1'b1};

  logic [ANCHO-1:0] cuenta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cuenta <= '0;
    end else if (load) begin
      cuenta <= valor;
    end else if (cuenta != '0) begin
      cuenta <= cuenta - UNO;
    end
  end

  assign cero = (cuenta == '0);

endmodule

// File: rtl/carro_ascensor.sv
// rtl/carro_ascensor.sv - per-car motion controller (travel timer + door hold)
//
// Purpose: accepts a destination floor from the dispatcher, moves the car one
// floor per T_VIAJE cycles, then holds the door open for T_PUERTA cycles.
// Ports:
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   destino[2:0]    requested floor; 3'b100 = none, 3'b0ff = floor index ff
//   piso[1:0]       current floor index
//   direccion[1:0]  00 stopped, 01 up, 10 down
//   ocupado         car busy, requests not accepted
//   puerta_abierta  door open
module carro_ascensor
  import ascensor_pkg::*;
#(
  parameter int T_VIAJE   = 100000000,
  parameter int T_PUERTA  = 100000000,
  parameter int ANCHO_CNT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] destino,
  output logic [1:0] piso,
  output logic [1:0] direccion,
  output logic       ocupado,
  output logic       puerta_abierta
);

  localparam logic [ANCHO_CNT-1:0] CARGA_VIAJE  = ANCHO_CNT'(T_VIAJE - 1);
  localparam logic [ANCHO_CNT-1:0] CARGA_PUERTA = ANCHO_CNT'(T_PUERTA - 1);

  estado_t              estado;
  logic [2:0]           ultimo_destino;
  logic [1:0]           objetivo;
  logic [1:0]           piso_sig;
  logic                 acepta;
  logic                 t_load;
  logic [ANCHO_CNT-1:0] t_valor;
  logic                 t_cero;

  // The dispatcher holds destino level, so a request is a change against the
  // last accepted value, only while idle.
  assign acepta = (estado == REPOSO) && !destino[2] && (destino != ultimo_destino);

  // Floor reached at the end of the current travel step. objetivo always lies
  // between piso and the direction of travel, so this never wraps.
  assign piso_sig = (direccion == DIR_ARRIBA) ? piso + 2'd1 : piso - 2'd1;

  // Timer reload: on accept, and on each floor step while moving.
  always_comb begin
    t_load  = 1'b0;
    t_valor = CARGA_VIAJE;
    case (estado)
      REPOSO: begin
        if (acepta) begin
          t_load  = 1'b1;
          t_valor = (destino[1:0] == piso) ? CARGA_PUERTA : CARGA_VIAJE;
        end
      end
      MOVIENDO: begin
        if (t_cero) begin
          t_load  = 1'b1;
          t_valor = (piso_sig == objetivo) ? CARGA_PUERTA : CARGA_VIAJE;
        end
      end
      default: ;
    endcase
  end

  temporizador_carga #(
    .ANCHO (ANCHO_CNT)
  ) u_temporizador (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (t_load),
    .valor (t_valor),
    .cero  (t_cero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado         <= REPOSO;
      piso           <= 2'b00;
      direccion      <= DIR_NADA;
      ocupado        <= 1'b0;
      puerta_abierta <= 1'b0;
      ultimo_destino <= DEST_NADA;
      objetivo       <= 2'b00;
    end else begin
      case (estado)
        REPOSO: begin
          if (acepta) begin
            ultimo_destino <= destino;
            objetivo       <= destino[1:0];
            ocupado        <= 1'b1;
            if (destino[1:0] > piso) begin
              estado    <= MOVIENDO;
              direccion <= DIR_ARRIBA;
            end else if (destino[1:0] < piso) begin
              estado    <= MOVIENDO;
              direccion <= DIR_ABAJO;
            end else begin
              estado         <= PUERTA;
              direccion      <= DIR_NADA;
              puerta_abierta <= 1'b1;
            end
          end else if (destino[2]) begin
            // "No request" re-arms the same floor for a later request.
            ultimo_destino <= DEST_NADA;
          end
        end
        MOVIENDO: begin
          if (t_cero) begin
            piso <= piso_sig;
            if (piso_sig == objetivo) begin
              estado         <= PUERTA;
              direccion      <= DIR_NADA;
              puerta_abierta <= 1'b1;
            end
          end
        end
        PUERTA: begin
          if (t_cero) begin
            estado         <= REPOSO;
            puerta_abierta <= 1'b0;
            ocupado        <= 1'b0;
          end
        end
        default: begin
          estado <= REPOSO;
        end
      endcase
    end
  end

endmodule
